sub_bytes_engine: RTL and testbench

- Parametrised, time-multiplexed AES byte-substitution unit: applies the forward S-box (SubBytes) or the inverse S-box (InvSubBytes) to all 16 bytes of a 128-bit state.
- LANES S-box instances are shared across the 16 bytes, so each block takes 16/LANES cycles. This trades area against throughput.
- Sits between AddRoundKey/ShiftRows stages in the iterative AES-256 encrypt and decrypt datapaths. Uses a valid/ready handshake on both sides.

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/sbox_dual.sv | 12 +
 rtl/sub_bytes_engine.sv | 125 ++++++++++++
 tb/tb_sub_bytes_engine.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/state types, S-box tables and engine FSM state type.
package aes_pkg;

  localparam int AES_NUM_BYTES = 16;

  typedef logic [7:0]                   byte_t;
  typedef logic [8*AES_NUM_BYTES-1:0]   state_t;
  typedef logic [0:255][7:0]            sbox_table_t;

  typedef enum logic [1:0] {
    SBE_IDLE,
    SBE_BUSY,
    SBE_DONE
  } sbe_state_t;

  // Element 0 is the most significant byte, so each row reads left to right.
  localparam sbox_table_t SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // The inverse S-box is the inverse permutation of the forward one.
  function automatic sbox_table_t invert_table(input sbox_table_t t);
    sbox_table_t r;
    r = '0;
    for (int i = 0; i < 256; i++) begin
      r[t[i]] = byte_t'(i);
    end
    return r;
  endfunction

  localparam sbox_table_t SBOX_INV = invert_table(SBOX_FWD);

endpackage

// File: rtl/sbox_dual.sv
// Combinational forward/inverse AES S-box lookup for one byte.
module sbox_dual
  import aes_pkg::*;
(
  input  logic  inv,
  input  byte_t din,
  output byte_t dout
);

  assign dout = inv ? SBOX_INV[din] : SBOX_FWD[din];

endmodule

// File: rtl/sub_bytes_engine.sv
// Time-multiplexed SubBytes/InvSubBytes over a 128-bit state using LANES shared
// S-boxes; one group of LANES bytes is substituted in place per BUSY cycle.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t data_in,
  input  logic   inv_in,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t data_out,
  output logic   busy
);

  localparam int GROUPS = AES_NUM_BYTES / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  sbe_state_t state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          mode_reg, mode_next;
  state_t        work_reg, work_next;

  // Byte-indexed views: element 0 is data bits [127:120].
  logic [0:AES_NUM_BYTES-1][7:0] work_bytes, next_bytes;
  logic [3:0]                    base_idx;
  byte_t                         lane_in  [LANES];
  byte_t                         lane_out [LANES];

  assign work_bytes = work_reg;
  assign work_next  = next_bytes;
  assign base_idx   = 4'(cnt_reg * LANES);
  assign data_out   = work_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_in[gi] = work_bytes[base_idx + 4'(gi)];

      sbox_dual u_sbox (
        .inv  (mode_reg),
        .din  (lane_in[gi]),
        .dout (lane_out[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    next_bytes = work_bytes;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;

    case (state_reg)
      SBE_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_bytes = data_in;
          mode_next  = inv_in;
          cnt_next   = '0;
          state_next = SBE_BUSY;
        end
      end

      SBE_BUSY: begin
        busy = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          next_bytes[base_idx + 4'(l)] = lane_out[l];
        end
        if (cnt_reg == CW'(GROUPS - 1)) begin
          cnt_next   = '0;
          state_next = SBE_DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      SBE_DONE: begin
        out_valid = 1'b1;
        // Accepting alongside the output handshake avoids a bubble cycle.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            next_bytes = data_in;
            mode_next  = inv_in;
            cnt_next   = '0;
            state_next = SBE_BUSY;
          end else begin
            state_next = SBE_IDLE;
          end
        end
      end

      default: state_next = SBE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SBE_IDLE;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
      work_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      work_reg  <= work_next;
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine at LANES=4,1,16 against a GF(2^8)-derived S-box and
// a transaction-timing model of the handshake.
module tb_sub_bytes_engine;
  import aes_pkg::*;

  localparam int NK = 3;

  localparam state_t ALL63  = {16{8'h63}};
  localparam state_t ALLED  = {16{8'hED}};
  localparam state_t ALL53  = {16{8'h53}};
  localparam state_t SEQ    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam state_t INVSEQ = 128'h52096AD53036A538BF40A39E81F3D7FB;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   in_valid_a  [NK];
  logic   inv_a       [NK];
  logic   out_ready_a [NK];
  state_t data_a      [NK];
  logic   in_ready_a  [NK];
  logic   out_valid_a [NK];
  logic   busy_a      [NK];
  state_t dout_a      [NK];

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] tb_fwd [256];
  logic [7:0] tb_inv [256];

  int     phase   [NK];
  int     cyc     [NK];
  int     done_at [NK];
  state_t exp_q   [NK];

  always #5 clk = ~clk;

  sub_bytes_engine #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .data_in(data_a[0]), .inv_in(inv_a[0]), .out_valid(out_valid_a[0]),
    .out_ready(out_ready_a[0]), .data_out(dout_a[0]), .busy(busy_a[0])
  );

  sub_bytes_engine #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .data_in(data_a[1]), .inv_in(inv_a[1]), .out_valid(out_valid_a[1]),
    .out_ready(out_ready_a[1]), .data_out(dout_a[1]), .busy(busy_a[1])
  );

  sub_bytes_engine #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .data_in(data_a[2]), .inv_in(inv_a[2]), .out_valid(out_valid_a[2]),
    .out_ready(out_ready_a[2]), .data_out(dout_a[2]), .busy(busy_a[2])
  );

  function automatic int lanes_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
  endfunction

  function automatic int groups_of(input int k);
    return 16 / lanes_of(k);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int i = 0; i < 8; i++) begin
      s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    end
    return s;
  endfunction

  function automatic state_t sub_state(input state_t d, input logic inv);
    state_t r;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = d[127-8*i -: 8];
      r[127-8*i -: 8] = inv ? tb_inv[b] : tb_fwd[b];
    end
    return r;
  endfunction

  function automatic state_t rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s lanes=%0d got=%h want=%h t=%0t", nm, lanes_of(k), act, exp, $time);
    end
  endtask

  task automatic wait_valid(input int k, output bit got);
    got = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (out_valid_a[k]) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // One block: wait for acceptance, scramble inputs while busy, return result and latency.
  task automatic xfer(input int k, input state_t d, input logic inv, output state_t res, output int lat);
    bit ok;
    @(negedge clk); #1;
    in_valid_a[k] = 1'b1; data_a[k] = d; inv_a[k] = inv; out_ready_a[k] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (in_ready_a[k]) ok = 1'b1;
      else @(negedge clk);
    end
    chk("accept_timeout", k, ok, 1'b1);
    @(posedge clk); #1;
    lat = -1;
    for (int j = 0; j < 40; j++) begin
      in_valid_a[k] = 1'($urandom_range(0, 1));
      data_a[k] = rand_state();
      inv_a[k]  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid_a[k]) begin
        lat = j;
        break;
      end
      #1;
    end
    res = dout_a[k];
    #1 in_valid_a[k] = 1'b0; out_ready_a[k] = 1'b1;
    @(posedge clk); #1 out_ready_a[k] = 1'b0;
  endtask

  task automatic rand_phase(input int k);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      in_valid_a[k]  = ($urandom_range(0, 2) != 0);
      data_a[k]      = rand_state();
      inv_a[k]       = 1'($urandom_range(0, 1));
      out_ready_a[k] = ($urandom_range(0, 3) != 0);
    end
    in_valid_a[k] = 1'b0;
  endtask

  initial begin
    state_t res, a_blk, b_blk;
    logic   ia, ib;
    int     lat;
    bit     got;

    rst_n = 1'b0;
    for (int k = 0; k < NK; k++) begin
      in_valid_a[k] = 1'b0; inv_a[k] = 1'b0; out_ready_a[k] = 1'b0; data_a[k] = '0;
      phase[k] = 0; cyc[k] = 0; done_at[k] = 0; exp_q[k] = '0;
    end

    for (int x = 0; x < 256; x++) begin
      logic [7:0] xi;
      xi = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
      end
      tb_fwd[x] = affine(xi);
    end
    for (int x = 0; x < 256; x++) tb_inv[tb_fwd[x]] = 8'(x);

    chk("pin_zero_fwd", 0, sub_state('0, 1'b0), ALL63);
    chk("pin_seq_inv", 0, sub_state(SEQ, 1'b1), INVSEQ);
    chk("pin_53_fwd", 0, tb_fwd[8'h53], 8'hED);

    fork
      begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
      end
      forever begin : model
        bit rdy;
        @(posedge clk or negedge rst_n);
        for (int k = 0; k < NK; k++) begin
          if (!rst_n) begin
            phase[k] = 0;
          end else begin
            rdy = (phase[k] == 0) || (phase[k] == 2 && out_ready_a[k]);
            cyc[k]++;
            if (phase[k] == 2 && out_ready_a[k]) phase[k] = 0;
            if (phase[k] == 1 && cyc[k] == done_at[k]) phase[k] = 2;
            if (in_valid_a[k] && rdy) begin
              phase[k]   = 1;
              done_at[k] = cyc[k] + groups_of(k);
              exp_q[k]   = sub_state(data_a[k], inv_a[k]);
            end
          end
        end
      end
      forever begin : compare
        @(negedge clk);
        if (rst_n) begin
          for (int k = 0; k < NK; k++) begin
            chk("model_in_ready", k, in_ready_a[k],
                (phase[k] == 0) || (phase[k] == 2 && out_ready_a[k]));
            chk("model_out_valid", k, out_valid_a[k], phase[k] == 2);
            chk("model_busy", k, busy_a[k], phase[k] == 1);
            if (phase[k] == 2) chk("model_data", k, dout_a[k], exp_q[k]);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      chk("rst_out_valid", k, out_valid_a[k], 1'b0);
      chk("rst_data_out", k, dout_a[k], '0);
      chk("rst_busy", k, busy_a[k], 1'b0);
    end
    #1 rst_n = 1'b1;
    #1;
    for (int k = 0; k < NK; k++) chk("rst_in_ready", k, in_ready_a[k], 1'b1);

    xfer(0, '0, 1'b0, res, lat);
    $display("xfer lanes=4 zeros fwd res=%h lat=%0d", res, lat);
    chk("zero_fwd", 0, res, ALL63);
    chk("zero_fwd_lat", 0, lat, 4);

    xfer(0, SEQ, 1'b1, res, lat);
    $display("xfer lanes=4 seq inv res=%h lat=%0d", res, lat);
    chk("seq_inv", 0, res, INVSEQ);
    chk("seq_inv_lat", 0, lat, 4);

    for (int k = 1; k < NK; k++) begin
      xfer(k, ALL53, 1'b0, res, lat);
      $display("xfer lanes=%0d 53 fwd res=%h lat=%0d", lanes_of(k), res, lat);
      chk("rt_fwd", k, res, ALLED);
      chk("rt_fwd_lat", k, lat, groups_of(k));
      xfer(k, ALLED, 1'b1, res, lat);
      $display("xfer lanes=%0d ED inv res=%h lat=%0d", lanes_of(k), res, lat);
      chk("rt_inv", k, res, ALL53);
      chk("rt_inv_lat", k, lat, groups_of(k));
    end

    a_blk = rand_state(); b_blk = rand_state();
    ia = 1'($urandom_range(0, 1)); ib = ~ia;
    @(negedge clk); #1;
    in_valid_a[0] = 1'b1; data_a[0] = a_blk; inv_a[0] = ia; out_ready_a[0] = 1'b0;
    #1 chk("hold_idle_ready", 0, in_ready_a[0], 1'b1);
    @(posedge clk); #1 in_valid_a[0] = 1'b0;
    wait_valid(0, got);
    chk("hold_reach_done", 0, got, 1'b1);
    #1 in_valid_a[0] = 1'b1; data_a[0] = b_blk; inv_a[0] = ib;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 0, out_valid_a[0], 1'b1);
      chk("hold_data", 0, dout_a[0], sub_state(a_blk, ia));
      chk("hold_in_ready", 0, in_ready_a[0], 1'b0);
    end
    #1 out_ready_a[0] = 1'b1;
    #1 chk("hs_in_ready", 0, in_ready_a[0], 1'b1);
    @(posedge clk); #1;
    chk("hs_valid_drop", 0, out_valid_a[0], 1'b0);
    chk("hs_new_busy", 0, busy_a[0], 1'b1);
    in_valid_a[0] = 1'b0; out_ready_a[0] = 1'b0;
    wait_valid(0, got);
    chk("hs_second_done", 0, got, 1'b1);
    chk("hs_second_data", 0, dout_a[0], sub_state(b_blk, ib));
    $display("hold lanes=4 second block res=%h", dout_a[0]);
    #1 out_ready_a[0] = 1'b1;
    @(posedge clk); #1 out_ready_a[0] = 1'b0;

    @(negedge clk); #1;
    in_valid_a[0] = 1'b1; data_a[0] = rand_state(); inv_a[0] = 1'b0;
    @(posedge clk); #1 in_valid_a[0] = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("midbusy_busy", 0, busy_a[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midbusy_rst_valid", 0, out_valid_a[0], 1'b0);
    chk("midbusy_rst_data", 0, dout_a[0], '0);
    chk("midbusy_rst_busy", 0, busy_a[0], 1'b0);
    @(negedge clk); #1 rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 0, in_ready_a[0], 1'b1);
    a_blk = rand_state();
    xfer(0, a_blk, 1'b1, res, lat);
    $display("xfer lanes=4 post-reset inv res=%h lat=%0d", res, lat);
    chk("post_rst_data", 0, res, sub_state(a_blk, 1'b1));
    chk("post_rst_lat", 0, lat, 4);

    fork
      rand_phase(0);
      rand_phase(1);
      rand_phase(2);
    join
    @(negedge clk); #1;
    for (int k = 0; k < NK; k++) out_ready_a[k] = 1'b1;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
